arbitro_rr_param: RTL and testbench

- Parametrised successor of the 4-port transaction-layer arbiter.
- Arbitrates NUM_PORTS input FIFOs and routes each popped word to one of NUM_PORTS output FIFOs, selected by the word's destination field.
- Output FIFOs apply backpressure through almost-full; words are never dropped.
- Adds round-robin or fixed-priority mode, a per-cycle enable, and an accepted-word counter.

---
 rtl/arbitro_rr_param_if.sv | 27 ++
 rtl/arbitro_rr_param.sv | 75 +++++++
 tb/tb_arbitro_rr_param.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/arbitro_rr_param_if.sv
// Bundle of the input-FIFO, output-FIFO and status signals around the arbiter.
// master is the arbiter side; slave is the FIFO/environment side.
interface arbitro_rr_param_if #(
  parameter int NUM_PORTS = 4,
  parameter int WORD_SIZE = 10,
  parameter int CNT_WIDTH = 8
);
  logic                           enable;
  logic [NUM_PORTS-1:0]           empty;
  logic [NUM_PORTS*WORD_SIZE-1:0] data_in;
  logic [NUM_PORTS-1:0]           almostfull;
  logic [NUM_PORTS-1:0]           pop;
  logic [NUM_PORTS-1:0]           push;
  logic [WORD_SIZE-1:0]           data_out;
  logic [CNT_WIDTH-1:0]           words_sent;
  logic                           idle;

  modport master (
    input  enable, empty, data_in, almostfull,
    output pop, push, data_out, words_sent, idle
  );

  modport slave (
    output enable, empty, data_in, almostfull,
    input  pop, push, data_out, words_sent, idle
  );
endinterface

// File: rtl/arbitro_rr_param.sv
// NUM_PORTS-way FIFO arbiter/router: pops one input word per cycle and pushes it
// to the output FIFO named by its top DEST_BITS, honouring almost-full backpressure.
module arbitro_rr_param #(
  parameter int NUM_PORTS = 4,
  parameter int WORD_SIZE = 10,
  parameter int DEST_BITS = 2,
  parameter int ARB_MODE  = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  arbitro_rr_param_if.master  bus
);
  logic [WORD_SIZE-1:0] word [NUM_PORTS];
  logic [DEST_BITS-1:0] dest [NUM_PORTS];
  logic [NUM_PORTS-1:0] eligible;

  logic                 grant_valid;
  logic [DEST_BITS-1:0] grant_idx;
  logic [DEST_BITS-1:0] cand;

  logic [NUM_PORTS-1:0] push_reg;
  logic [WORD_SIZE-1:0] data_out_reg;
  logic [CNT_WIDTH-1:0] words_sent_reg;
  logic                 idle_reg;
  logic [DEST_BITS-1:0] ptr_reg;

  // Almost-full margin of at least one word covers the push already in flight.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign word[gi]     = bus.data_in[gi*WORD_SIZE +: WORD_SIZE];
    assign dest[gi]     = word[gi][WORD_SIZE-1 -: DEST_BITS];
    assign eligible[gi] = bus.enable & ~reset & ~bus.empty[gi] & ~bus.almostfull[dest[gi]];
  end

  // Search order starts at ptr in round-robin mode, at port 0 in fixed priority.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (ARB_MODE == 1) ? ptr_reg + DEST_BITS'(k) : DEST_BITS'(k);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign bus.pop = grant_valid ? (NUM_PORTS'(1) << grant_idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_reg       <= '0;
      data_out_reg   <= '0;
      words_sent_reg <= '0;
      idle_reg       <= 1'b1;
      ptr_reg        <= '0;
    end else if (grant_valid) begin
      push_reg       <= NUM_PORTS'(1) << dest[grant_idx];
      data_out_reg   <= word[grant_idx];
      words_sent_reg <= words_sent_reg + 1'b1;
      idle_reg       <= 1'b0;
      if (ARB_MODE == 1)
        ptr_reg <= grant_idx + 1'b1;
    end else begin
      push_reg <= '0;
      idle_reg <= 1'b1;
    end
  end

  assign bus.push       = push_reg;
  assign bus.data_out   = data_out_reg;
  assign bus.words_sent = words_sent_reg;
  assign bus.idle       = idle_reg;
endmodule

// File: tb/tb_arbitro_rr_param.sv
// Directed bench: round-robin, fixed-priority and 4-bit-counter instances share one stimulus.
module tb_arbitro_rr_param;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  empty = 4'b1111;
  logic [3:0]  almostfull = 4'b0000;
  logic [39:0] data_in = {10'h345, 10'h017, 10'h2B7, 10'h1A6};

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  arbitro_rr_param_if #(.NUM_PORTS(4), .WORD_SIZE(10), .CNT_WIDTH(8)) bus_rr ();
  arbitro_rr_param_if #(.NUM_PORTS(4), .WORD_SIZE(10), .CNT_WIDTH(8)) bus_fp ();
  arbitro_rr_param_if #(.NUM_PORTS(4), .WORD_SIZE(10), .CNT_WIDTH(4)) bus_c4 ();

  assign bus_rr.enable = enable;  assign bus_rr.empty = empty;
  assign bus_rr.data_in = data_in; assign bus_rr.almostfull = almostfull;
  assign bus_fp.enable = enable;  assign bus_fp.empty = empty;
  assign bus_fp.data_in = data_in; assign bus_fp.almostfull = almostfull;
  assign bus_c4.enable = enable;  assign bus_c4.empty = empty;
  assign bus_c4.data_in = data_in; assign bus_c4.almostfull = almostfull;

  arbitro_rr_param #(.NUM_PORTS(4), .WORD_SIZE(10), .DEST_BITS(2), .ARB_MODE(1), .CNT_WIDTH(8))
    dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));
  arbitro_rr_param #(.NUM_PORTS(4), .WORD_SIZE(10), .DEST_BITS(2), .ARB_MODE(0), .CNT_WIDTH(8))
    dut_fp (.clk(clk), .reset(reset), .bus(bus_fp));
  arbitro_rr_param #(.NUM_PORTS(4), .WORD_SIZE(10), .DEST_BITS(2), .ARB_MODE(1), .CNT_WIDTH(4))
    dut_c4 (.clk(clk), .reset(reset), .bus(bus_c4));

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    empty = 4'b0000; almostfull = 4'b0000; enable = 1'b1;
    reset = 1'b1; #1;
    total++; if (bus_rr.pop !== 4'b0000) $display("FAIL reset_pop: got %b expected 0000", bus_rr.pop); else passed++;
    total++; if (bus_rr.push !== 4'b0000) $display("FAIL reset_push: got %b expected 0000", bus_rr.push); else passed++;
    total++; if (bus_rr.data_out !== 10'h000) $display("FAIL reset_data: got %h expected 000", bus_rr.data_out); else passed++;
    total++; if (bus_rr.words_sent !== 8'd0) $display("FAIL reset_count: got %0d expected 0", bus_rr.words_sent); else passed++;
    total++; if (bus_rr.idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", bus_rr.idle); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset: pop=%b push=%b idle=%b", bus_rr.pop, bus_rr.push, bus_rr.idle);
  endtask

  task automatic test_round_robin;
    int gs[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_push[4] = '{4'b0010, 4'b0100, 4'b0001, 4'b1000};
    logic [9:0] words[4] = '{10'h1A6, 10'h2B7, 10'h017, 10'h345};
    do_reset();
    empty = 4'b0000; almostfull = 4'b0000; enable = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus_rr.pop !== 4'(1 << gs[i])) $display("FAIL rr_pop%0d: got %b expected %b", i, bus_rr.pop, 4'(1 << gs[i])); else passed++;
      @(posedge clk); #1;
      total++; if (bus_rr.push !== exp_push[gs[i]]) $display("FAIL rr_push%0d: got %b expected %b", i, bus_rr.push, exp_push[gs[i]]); else passed++;
      total++; if (bus_rr.data_out !== words[gs[i]]) $display("FAIL rr_data%0d: got %h expected %h", i, bus_rr.data_out, words[gs[i]]); else passed++;
      total++; if (bus_rr.words_sent !== 8'(i + 1)) $display("FAIL rr_count%0d: got %0d expected %0d", i, bus_rr.words_sent, i + 1); else passed++;
      $display("rr grant %0d: port=%0d push=%b data=%h count=%0d", i, gs[i], bus_rr.push, bus_rr.data_out, bus_rr.words_sent);
    end
  endtask

  task automatic test_almostfull;
    logic [3:0] exp_pop[4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    logic [3:0] exp_push[4] = '{4'b0100, 4'b1000, 4'b0100, 4'b1000};
    do_reset();
    // destinations 0 and 1 full: ports 2 and 0 blocked
    empty = 4'b0000; almostfull = 4'b0011; #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus_rr.pop !== exp_pop[i]) $display("FAIL af_pop%0d: got %b expected %b", i, bus_rr.pop, exp_pop[i]); else passed++;
      @(posedge clk); #1;
      total++; if (bus_rr.push !== exp_push[i]) $display("FAIL af_push%0d: got %b expected %b", i, bus_rr.push, exp_push[i]); else passed++;
      $display("af grant %0d: push=%b", i, bus_rr.push);
    end
    almostfull = 4'b0000; #1;
    total++; if (bus_rr.pop !== 4'b0001) $display("FAIL af_resume: got %b expected 0001", bus_rr.pop); else passed++;
    $display("af cleared: pop=%b", bus_rr.pop);
  endtask

  task automatic test_fixed_priority;
    do_reset();
    empty = 4'b0000; almostfull = 4'b0000; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus_fp.pop !== 4'b0001) $display("FAIL fp_pop%0d: got %b expected 0001", i, bus_fp.pop); else passed++;
      @(posedge clk); #1;
      total++; if (bus_fp.push !== 4'b0010) $display("FAIL fp_push%0d: got %b expected 0010", i, bus_fp.push); else passed++;
      $display("fp grant %0d: push=%b", i, bus_fp.push);
    end
    empty = 4'b0001; #1;
    total++; if (bus_fp.pop !== 4'b0010) $display("FAIL fp_pop_next: got %b expected 0010", bus_fp.pop); else passed++;
    @(posedge clk); #1;
    total++; if (bus_fp.push !== 4'b0100) $display("FAIL fp_push_next: got %b expected 0100", bus_fp.push); else passed++;
    total++; if (bus_fp.data_out !== 10'h2B7) $display("FAIL fp_data_next: got %h expected 2b7", bus_fp.data_out); else passed++;
    $display("fp port0 empty: push=%b data=%h", bus_fp.push, bus_fp.data_out);
  endtask

  task automatic test_idle;
    do_reset();
    empty = 4'b0000; almostfull = 4'b0000; #1;
    @(posedge clk); #1;
    total++; if (bus_rr.idle !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus_rr.idle); else passed++;
    empty = 4'b1111; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus_rr.pop !== 4'b0000) $display("FAIL idle_pop%0d: got %b expected 0000", i, bus_rr.pop); else passed++;
      @(posedge clk); #1;
      total++; if (bus_rr.push !== 4'b0000) $display("FAIL idle_push%0d: got %b expected 0000", i, bus_rr.push); else passed++;
      total++; if (bus_rr.idle !== 1'b1) $display("FAIL idle_flag%0d: got %b expected 1", i, bus_rr.idle); else passed++;
      total++; if (bus_rr.data_out !== 10'h1A6) $display("FAIL idle_hold%0d: got %h expected 1a6", i, bus_rr.data_out); else passed++;
      $display("idle cycle %0d: push=%b idle=%b data=%h", i, bus_rr.push, bus_rr.idle, bus_rr.data_out);
    end
  endtask

  task automatic test_enable;
    do_reset();
    empty = 4'b0000; almostfull = 4'b0000; enable = 1'b1; #1;
    @(posedge clk); #1;
    enable = 1'b0; #1;
    total++; if (bus_rr.pop !== 4'b0000) $display("FAIL en_pop: got %b expected 0000", bus_rr.pop); else passed++;
    total++; if (bus_rr.push !== 4'b0010) $display("FAIL en_push_done: got %b expected 0010", bus_rr.push); else passed++;
    @(posedge clk); #1;
    total++; if (bus_rr.push !== 4'b0000) $display("FAIL en_push_off: got %b expected 0000", bus_rr.push); else passed++;
    total++; if (bus_rr.words_sent !== 8'd1) $display("FAIL en_count: got %0d expected 1", bus_rr.words_sent); else passed++;
    $display("enable low: push=%b count=%0d", bus_rr.push, bus_rr.words_sent);
    enable = 1'b1;
  endtask

  task automatic test_reset_midstream;
    do_reset();
    empty = 4'b0000; almostfull = 4'b0000; #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bus_rr.push !== 4'b0100) $display("FAIL mid_pending: got %b expected 0100", bus_rr.push); else passed++;
    reset = 1'b1; #1;
    total++; if (bus_rr.push !== 4'b0000) $display("FAIL mid_push: got %b expected 0000", bus_rr.push); else passed++;
    total++; if (bus_rr.data_out !== 10'h000) $display("FAIL mid_data: got %h expected 000", bus_rr.data_out); else passed++;
    total++; if (bus_rr.words_sent !== 8'd0) $display("FAIL mid_count: got %0d expected 0", bus_rr.words_sent); else passed++;
    total++; if (bus_rr.pop !== 4'b0000) $display("FAIL mid_pop: got %b expected 0000", bus_rr.pop); else passed++;
    $display("mid reset: push=%b data=%h count=%0d", bus_rr.push, bus_rr.data_out, bus_rr.words_sent);
    reset = 1'b0;
  endtask

  task automatic test_wrap;
    do_reset();
    empty = 4'b0000; almostfull = 4'b0000; #1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i == 16) begin
        total++; if (bus_c4.words_sent !== 4'd0) $display("FAIL wrap16: got %0d expected 0", bus_c4.words_sent); else passed++;
      end
    end
    total++; if (bus_c4.words_sent !== 4'd1) $display("FAIL wrap17: got %0d expected 1", bus_c4.words_sent); else passed++;
    total++; if (bus_rr.words_sent !== 8'd17) $display("FAIL count17: got %0d expected 17", bus_rr.words_sent); else passed++;
    $display("wrap: c4 count=%0d rr count=%0d", bus_c4.words_sent, bus_rr.words_sent);
  endtask

  initial begin
    #2;
    test_reset();
    test_round_robin();
    test_almostfull();
    test_fixed_priority();
    test_idle();
    test_enable();
    test_reset_midstream();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
